// File: rtl/decoder_proj_pkg.sv
// Shared definitions for the hex-to-seven-segment decoder: io_in field map,
// the segment lookup table and the combinational decode function.
package decoder_proj_pkg;

  localparam int IO_W     = 7;
  localparam int CODE_W   = 4;
  localparam int SEG_W    = 7;

  localparam int CLK      = 0;
  localparam int RST      = 1;
  localparam int CODE_LSB = 2;
  localparam int CODE_MSB = 5;
  localparam int EN       = 6;

  // Segment order is {g,f,e,d,c,b,a}; entry 0 sits in the low slice.
  localparam logic [15:0][SEG_W-1:0] DEC_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  function automatic logic [SEG_W-1:0] dec7(input logic [CODE_W-1:0] code);
    return DEC_TABLE[code];
  endfunction

endpackage

// File: rtl/decoder_proj.sv
// Registered hex-to-seven-segment decoder core: loads a decoded digit when
// enabled, otherwise holds; reset clears the display and the valid flag.
module decoder_proj
  import decoder_proj_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic [CODE_W-1:0] code,
  input  logic              en,
  output logic [SEG_W-1:0]  seg,
  output logic              valid
);

  logic [SEG_W-1:0] seg_d,   seg_q;
  logic             valid_d, valid_q;

  always_comb begin
    seg_d   = seg_q;
    valid_d = valid_q;
    if (en) begin
      seg_d   = dec7(code);
      valid_d = 1'b1;
    end
  end

  // Reset wins over a simultaneous load.
  always_ff @(posedge clk) begin
    if (rst) begin
      seg_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      seg_q   <= seg_d;
      valid_q <= valid_d;
    end
  end

  assign seg   = seg_q;
  assign valid = valid_q;

endmodule

// File: rtl/decoder_proj_formal_top.sv
// Formal top: slices the user I/O bus onto the decoder core and, in formal
// builds, carries the assumptions, assertions and covers for the core.
module decoder_proj_formal_top
  import decoder_proj_pkg::*;
(
  input logic [IO_W-1:0] io_in
);

  logic              clk;
  logic              rst;
  logic [CODE_W-1:0] code;
  logic              en;
  logic [SEG_W-1:0]  seg;
  logic              valid;

  assign clk  = io_in[CLK];
  assign rst  = io_in[RST];
  assign code = io_in[CODE_MSB:CODE_LSB];
  assign en   = io_in[EN];

  decoder_proj u_core (
    .clk   (clk),
    .rst   (rst),
    .code  (code),
    .en    (en),
    .seg   (seg),
    .valid (valid)
  );

`ifdef FORMAL
  // Start from a reset so every later $past refers to a defined cycle.
  logic f_past_vld = 1'b0;

  always @(posedge clk) begin
    f_past_vld <= 1'b1;
  end

  always @(*) begin
    if (!f_past_vld) assume (rst);
  end

  always @(posedge clk) begin
    if (f_past_vld) begin
      if ($past(rst)) begin
        assert (seg == '0 && !valid);
      end else if ($past(en)) begin
        assert (seg == dec7($past(code)) && valid);
      end else begin
        assert ($stable(seg) && $stable(valid));
      end
    end
  end

  always @(*) begin
    if (!valid) assert (seg == '0);
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_cover_code
    always @(posedge clk) begin
      cover (!rst && en && code == gi[CODE_W-1:0]);
    end
  end

  always @(posedge clk) begin
    cover (!rst && !en && valid);
  end
`endif

endmodule

// File: tb/tb_decoder_proj_formal_top.sv
// Directed bench for decoder_proj_formal_top; observes the core outputs
// hierarchically one time unit after each rising clock edge.
module tb_decoder_proj_formal_top;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic [3:0] code = 4'h0;
  logic [6:0] io_in;

  int total = 0;
  int bad   = 0;

  logic [6:0] exp_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F,
                               7'h66, 7'h6D, 7'h7D, 7'h07,
                               7'h7F, 7'h6F, 7'h77, 7'h7C,
                               7'h39, 7'h5E, 7'h79, 7'h71};

  assign io_in = {en, code, rst, clk};

  decoder_proj_formal_top dut (
    .io_in (io_in)
  );

  wire [6:0] seg_obs   = dut.u_core.seg;
  wire       valid_obs = dut.u_core.valid;

  always #5 clk = ~clk;

  task automatic step(input logic r, input logic e, input logic [3:0] c);
    rst  = r;
    en   = e;
    code = c;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [6:0] exp_seg, input logic exp_vld);
    total++;
    assert ({valid_obs, seg_obs} === {exp_vld, exp_seg})
    else begin
      bad++;
      $error("FAIL %s: got valid=%0b seg=%h, expected valid=%0b seg=%h",
             tag, valid_obs, seg_obs, exp_vld, exp_seg);
    end
  endtask

  initial begin
    // Reset held two cycles with a pending load.
    step(1'b1, 1'b1, 4'h8);
    check("reset_c1", 7'h00, 1'b0);
    step(1'b1, 1'b1, 4'h8);
    check("reset_c2", 7'h00, 1'b0);

    step(1'b0, 1'b0, 4'h5);
    check("idle_after_reset", 7'h00, 1'b0);

    step(1'b0, 1'b1, 4'hA);
    check("single_load_A", 7'h77, 1'b1);

    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b1, 4'(i));
      check($sformatf("sweep_%0h", i), exp_tab[i], 1'b1);
    end

    step(1'b0, 1'b1, 4'h3);
    check("hold_load_3", 7'h4F, 1'b1);
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 1'b0, 4'h9);
      check($sformatf("hold_c%0d", i), 7'h4F, 1'b1);
    end

    // Glitch between edges: only the values present at the edge count.
    rst = 1'b0; en = 1'b1; code = 4'hF;
    #2;
    step(1'b0, 1'b0, 4'h2);
    check("glitch_ignored", 7'h4F, 1'b1);

    step(1'b0, 1'b1, 4'h7);
    check("prio_load_7", 7'h07, 1'b1);
    step(1'b1, 1'b1, 4'hE);
    check("prio_reset", 7'h00, 1'b0);
    step(1'b0, 1'b1, 4'hE);
    check("prio_release_E", 7'h79, 1'b1);

    step(1'b0, 1'b1, 4'hB);
    check("b2b_b", 7'h7C, 1'b1);
    step(1'b0, 1'b1, 4'hD);
    check("b2b_d", 7'h5E, 1'b1);
    step(1'b1, 1'b0, 4'h0);
    check("reset_no_en", 7'h00, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
